// File: rtl/responder_arbiter.sv
// responder_arbiter
// -----------------
// Shares a single authentication responder between NUM_REQ requesters.
// A round-robin arbiter picks one requester, latches its message, and
// drives the responder's req/msg/ack handshake on its behalf. The response
// is returned only to the granted requester. Every responder-facing wait is
// bounded by a TIMEOUT-cycle supervisor. When the supervisor expires, the
// responder gets a one-cycle reset pulse and the owner gets a one-cycle
// timeout pulse.
//
// Ports
//   clk            clock; everything is updated on posedge
//   reset          synchronous, active-high
//   req_in         level request, one bit per requester
//   msg_in         requester i message at [i*MSG_LEN +: MSG_LEN]
//   ack_in         requester has consumed its response (owner's bit only)
//   grant_out      one-hot current owner, 0 when idle
//   resp_valid_out response valid, only ever the owner's bit
//   resp_msg_out   response message captured from the responder
//   timeout_out    one-cycle pulse to the owner on abort
//   rsp_req        request to responder
//   rsp_msg        latched message to responder
//   rsp_ack        acknowledge to responder
//   rsp_reset      one-cycle reset pulse to responder on abort
//   rsp_done       responder "response ready" (held until it sees rsp_ack)
//   rsp_msg_back   responder response message
module responder_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int MSG_LEN = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_in,
    input  logic [NUM_REQ*MSG_LEN-1:0] msg_in,
    input  logic [NUM_REQ-1:0]         ack_in,
    output logic [NUM_REQ-1:0]         grant_out,
    output logic [NUM_REQ-1:0]         resp_valid_out,
    output logic [MSG_LEN-1:0]         resp_msg_out,
    output logic [NUM_REQ-1:0]         timeout_out,
    output logic                       rsp_req,
    output logic [MSG_LEN-1:0]         rsp_msg,
    output logic                       rsp_ack,
    output logic                       rsp_reset,
    input  logic                       rsp_done,
    input  logic [MSG_LEN-1:0]         rsp_msg_back
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PTR_RST  = PW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        DELIVER = 3'd2,
        RELEASE = 3'd3,
        ABORT   = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic [PW-1:0]        ptr_reg, ptr_next;        // last granted requester
    logic [PW-1:0]        owner_reg, owner_next;    // index form of grant
    logic [NUM_REQ-1:0]   grant_reg, grant_next;
    logic [NUM_REQ-1:0]   resp_valid_reg, resp_valid_next;
    logic [MSG_LEN-1:0]   resp_msg_reg, resp_msg_next;
    logic [NUM_REQ-1:0]   timeout_reg, timeout_next;
    logic                 rsp_req_reg, rsp_req_next;
    logic [MSG_LEN-1:0]   rsp_msg_reg, rsp_msg_next;
    logic                 rsp_ack_reg, rsp_ack_next;
    logic                 rsp_reset_reg, rsp_reset_next;
    logic [CW-1:0]        cnt_reg, cnt_next;

    // Unpack the flat message bus so the winner can be selected by index.
    logic [MSG_LEN-1:0] msg_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign msg_arr[gi] = msg_in[gi*MSG_LEN +: MSG_LEN];
        end
    endgenerate

    // Round-robin search starting at ptr+1. The loop walks the offsets from
    // farthest to nearest. Because a later assignment overrides an earlier
    // one, the nearest requesting index wins.
    logic [PW-1:0] win_idx;
    logic          win_found;
    logic [PW-1:0] cand;

    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = PW'((int'(ptr_reg) + off) % NUM_REQ);
            if (req_in[cand]) begin
                win_idx   = cand;
                win_found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic.
    logic go_abort;

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        owner_next      = owner_reg;
        grant_next      = grant_reg;
        resp_valid_next = resp_valid_reg;
        resp_msg_next   = resp_msg_reg;
        timeout_next    = '0;
        rsp_req_next    = rsp_req_reg;
        rsp_msg_next    = rsp_msg_reg;
        rsp_ack_next    = rsp_ack_reg;
        rsp_reset_next  = 1'b0;
        cnt_next        = cnt_reg;
        go_abort        = 1'b0;

        case (state_reg)
            IDLE: begin
                // rsp_done is deliberately not looked at here; a stale
                // level left over from a previous transaction is harmless.
                if (win_found) begin
                    owner_next          = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                    rsp_msg_next        = msg_arr[win_idx];
                    rsp_req_next        = 1'b1;
                    cnt_next            = '0;
                    state_next          = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next = cnt_reg + CW'(1);
                // Completion takes priority over expiry in the same cycle.
                if (rsp_done) begin
                    resp_msg_next   = rsp_msg_back;
                    rsp_req_next    = 1'b0;
                    resp_valid_next = grant_reg;
                    cnt_next        = '0;
                    state_next      = DELIVER;
                end else if (cnt_reg == CNT_LAST) begin
                    go_abort = 1'b1;
                end
            end
            DELIVER: begin
                // The supervisor is paused here. The requester may stall
                // for as long as it likes without the responder timing out.
                if (ack_in[owner_reg]) begin
                    resp_valid_next = '0;
                    rsp_ack_next    = 1'b1;
                    cnt_next        = '0;
                    state_next      = RELEASE;
                end
            end
            RELEASE: begin
                cnt_next = cnt_reg + CW'(1);
                if (!rsp_done) begin
                    rsp_ack_next = 1'b0;
                    grant_next   = '0;
                    ptr_next     = owner_reg;
                    cnt_next     = '0;
                    state_next   = IDLE;
                end else if (cnt_reg == CNT_LAST) begin
                    go_abort = 1'b1;
                end
            end
            ABORT: begin
                grant_next = '0;
                ptr_next   = owner_reg;
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Shared entry into ABORT. The pulses are registered, so they are
        // visible exactly while the state register holds ABORT.
        if (go_abort) begin
            rsp_reset_next  = 1'b1;
            timeout_next    = grant_reg;
            rsp_req_next    = 1'b0;
            rsp_ack_next    = 1'b0;
            resp_valid_next = '0;
            cnt_next        = '0;
            state_next      = ABORT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            ptr_reg        <= PTR_RST;
            owner_reg      <= '0;
            grant_reg      <= '0;
            resp_valid_reg <= '0;
            resp_msg_reg   <= '0;
            timeout_reg    <= '0;
            rsp_req_reg    <= 1'b0;
            rsp_msg_reg    <= '0;
            rsp_ack_reg    <= 1'b0;
            rsp_reset_reg  <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            owner_reg      <= owner_next;
            grant_reg      <= grant_next;
            resp_valid_reg <= resp_valid_next;
            resp_msg_reg   <= resp_msg_next;
            timeout_reg    <= timeout_next;
            rsp_req_reg    <= rsp_req_next;
            rsp_msg_reg    <= rsp_msg_next;
            rsp_ack_reg    <= rsp_ack_next;
            rsp_reset_reg  <= rsp_reset_next;
            cnt_reg        <= cnt_next;
        end
    end

    assign grant_out      = grant_reg;
    assign resp_valid_out = resp_valid_reg;
    assign resp_msg_out   = resp_msg_reg;
    assign timeout_out    = timeout_reg;
    assign rsp_req        = rsp_req_reg;
    assign rsp_msg        = rsp_msg_reg;
    assign rsp_ack        = rsp_ack_reg;
    assign rsp_reset      = rsp_reset_reg;

endmodule

// File: tb/tb_responder_arbiter.sv
// Directed and randomized bench for responder_arbiter (2 requesters,
// TIMEOUT=16). The responder is modelled inline by the stimulus. Expected
// owners come from a round-robin rule on the last-served index. Expected
// timing comes from cycle counts measured from the grant.
module tb_responder_arbiter;

    localparam int N  = 2;
    localparam int W  = 16;
    localparam int TO = 16;
    localparam int PW = $clog2(N);

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_in;
    logic [N*W-1:0]   msg_in;
    logic [N-1:0]     ack_in;
    logic [N-1:0]     grant_out;
    logic [N-1:0]     resp_valid_out;
    logic [W-1:0]     resp_msg_out;
    logic [N-1:0]     timeout_out;
    logic             rsp_req;
    logic [W-1:0]     rsp_msg;
    logic             rsp_ack;
    logic             rsp_reset;
    logic             rsp_done;
    logic [W-1:0]     rsp_msg_back;

    responder_arbiter #(.NUM_REQ(N), .MSG_LEN(W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .msg_in(msg_in),
        .ack_in(ack_in), .grant_out(grant_out),
        .resp_valid_out(resp_valid_out), .resp_msg_out(resp_msg_out),
        .timeout_out(timeout_out), .rsp_req(rsp_req), .rsp_msg(rsp_msg),
        .rsp_ack(rsp_ack), .rsp_reset(rsp_reset), .rsp_done(rsp_done),
        .rsp_msg_back(rsp_msg_back)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    int          last_ptr;          // model: index of last served requester
    bit          mon_en = 1'b0;
    logic [W-1:0] tb_msg [N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive_msgs();
        for (int i = 0; i < N; i++) msg_in[i*W +: W] = tb_msg[i];
    endtask

    task automatic rand_msgs();
        for (int i = 0; i < N; i++) tb_msg[i] = W'($urandom);
        drive_msgs();
    endtask

    // Round-robin rule: first requesting index after the last one served.
    function automatic int rr_pick(input logic [N-1:0] req, input int ptr);
        logic [PW-1:0] ix;
        for (int off = 1; off <= N; off++) begin
            ix = PW'((ptr + off) % N);
            if (req[ix]) return (ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, grant_out, 0);
        chk({tag, "_valid"}, resp_valid_out, 0);
        chk({tag, "_rmsg"}, resp_msg_out, 0);
        chk({tag, "_tmo"}, timeout_out, 0);
        chk({tag, "_req"}, rsp_req, 0);
        chk({tag, "_msg"}, rsp_msg, 0);
        chk({tag, "_ack"}, rsp_ack, 0);
        chk({tag, "_rst"}, rsp_reset, 0);
    endtask

    // Invariants checked on every cycle after reset is released.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv_onehot", $onehot0(grant_out), 1);
            chk("inv_subset", (resp_valid_out & ~grant_out) == '0, 1);
            chk("inv_req_ack", rsp_req & rsp_ack, 0);
        end
    end

    // mode 0: normal, mode 1: responder stuck in release, mode 2: reset in DELIVER
    task automatic txn(input logic [N-1:0] req, input int dly, input int bp,
                       input int rel, input int mode);
        int            idx;
        logic [PW-1:0] ix;
        logic [N-1:0]  g;
        logic [W-1:0]  exp_a;
        logic [W-1:0]  back;
        idx   = rr_pick(req, last_ptr);
        ix    = PW'(idx);
        g     = '0;
        g[ix] = 1'b1;
        exp_a = tb_msg[ix];
        back  = W'($urandom);
        req_in = req;
        tick();
        chk("grant", grant_out, g);
        chk("rsp_req", rsp_req, 1);
        chk("rsp_msg", rsp_msg, exp_a);
        // Requesters may change their bus or drop req; the latched copy holds.
        for (int c = 0; c < dly; c++) begin
            rand_msgs();
            req_in = N'($urandom);
            tick();
            chk("issue_req", rsp_req, 1);
            chk("issue_msg", rsp_msg, exp_a);
            chk("issue_tmo", timeout_out, 0);
        end
        rsp_done = 1'b1;
        rsp_msg_back = back;
        tick();
        chk("resp_valid", resp_valid_out, g);
        chk("resp_msg", resp_msg_out, back);
        chk("rsp_req_low", rsp_req, 0);
        chk("no_timeout", timeout_out, 0);
        rsp_msg_back = W'($urandom);
        if (mode == 2) begin
            reset = 1'b1;
            tick();
            chk_all_zero("rst_deliver");
            reset = 1'b0;
            rsp_done = 1'b0;
            req_in = '0;
            last_ptr = N - 1;
            $display("txn reset-in-deliver owner=%0d errors=%0d", idx, errors);
            return;
        end
        for (int c = 0; c < bp; c++) begin
            ack_in = (c == 0) ? ~g : (~g & N'($urandom));
            tick();
            chk("bp_valid", resp_valid_out, g);
            chk("bp_msg", resp_msg_out, back);
        end
        ack_in = g;
        tick();
        ack_in = '0;
        chk("rsp_ack", rsp_ack, 1);
        chk("valid_clr", resp_valid_out, 0);
        if (mode == 1) begin
            for (int c = 1; c < TO; c++) begin
                tick();
                chk("stuck_ack", rsp_ack, 1);
                chk("stuck_norst", rsp_reset, 0);
            end
            tick();
            chk("rel_abort_ack", rsp_ack, 0);
            chk("rel_abort_rst", rsp_reset, 1);
            chk("rel_abort_tmo", timeout_out, g);
            rsp_done = 1'b0;
            tick();
            chk("post_abort_grant", grant_out, 0);
            chk("post_abort_rst", rsp_reset, 0);
            chk("post_abort_tmo", timeout_out, 0);
        end else begin
            for (int c = 0; c < rel; c++) begin
                tick();
                chk("rel_ack", rsp_ack, 1);
                chk("rel_grant", grant_out, g);
            end
            rsp_done = 1'b0;
            tick();
            chk("ack_drop", rsp_ack, 0);
            chk("grant_idle", grant_out, 0);
        end
        req_in = '0;
        last_ptr = idx;
        $display("txn owner=%0d req=%b dly=%0d bp=%0d mode=%0d errors=%0d",
                 idx, req, dly, bp, mode, errors);
    endtask

    // Responder never answers: abort exactly TO cycles after rsp_req rises.
    task automatic issue_timeout(input logic [N-1:0] req);
        int            idx;
        logic [PW-1:0] ix;
        logic [N-1:0]  g;
        idx   = rr_pick(req, last_ptr);
        ix    = PW'(idx);
        g     = '0;
        g[ix] = 1'b1;
        req_in = req;
        tick();
        chk("to_grant", grant_out, g);
        for (int c = 1; c < TO; c++) begin
            tick();
            chk("to_wait_req", rsp_req, 1);
            chk("to_wait_rst", rsp_reset, 0);
        end
        tick();
        chk("to_rst", rsp_reset, 1);
        chk("to_tmo", timeout_out, g);
        chk("to_req_low", rsp_req, 0);
        tick();
        chk("to_rst_end", rsp_reset, 0);
        chk("to_tmo_end", timeout_out, 0);
        chk("to_grant_end", grant_out, 0);
        req_in = '0;
        last_ptr = idx;
        $display("txn timeout owner=%0d errors=%0d", idx, errors);
    endtask

    initial begin
        reset = 1'b1;
        req_in = '0;
        ack_in = '0;
        rsp_done = 1'b0;
        rsp_msg_back = '0;
        rand_msgs();
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        mon_en = 1'b1;
        last_ptr = N - 1;

        // Single transaction, requester 0, responder answers after 5 cycles.
        tb_msg[0] = 16'hA5A5;
        drive_msgs();
        txn(2'b01, 5, 2, 1, 0);

        // Round robin with both requesting continuously.
        for (int t = 0; t < 4; t++) txn(2'b11, $urandom_range(0, 6), 1, 1, 0);

        // Timeout in ISSUE, then the next request is accepted.
        issue_timeout(2'b01);
        txn(2'b01, 2, 0, 0, 0);

        // Responder stuck holding rsp_done after ack.
        txn(2'b10, 3, 0, 0, 1);

        // Completion on the very cycle the supervisor would expire.
        txn(2'b01, TO - 1, 1, 1, 0);

        // Stale rsp_done while idle is ignored.
        rsp_done = 1'b1;
        tick();
        tick();
        chk("stale_grant", grant_out, 0);
        chk("stale_req", rsp_req, 0);
        chk("stale_valid", resp_valid_out, 0);
        rsp_done = 1'b0;

        // Reset in DELIVER: pointer restarts so requester 0 wins next.
        txn(2'b01, 1, 0, 0, 0);
        txn(2'b11, 2, 1, 0, 2);
        txn(2'b11, 1, 0, 0, 0);

        // Randomized traffic.
        for (int t = 0; t < 24; t++) begin
            int r;
            logic [N-1:0] rq;
            r = $urandom_range(0, 9);
            rq = N'($urandom_range(1, (1 << N) - 1));
            rand_msgs();
            if (r == 0) issue_timeout(rq);
            else txn(rq, $urandom_range(0, TO - 1), $urandom_range(0, 3),
                     $urandom_range(0, 4), (r == 1) ? 1 : 0);
        end

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
